// File: rtl/krnl_proj_split_dbg_pkg.sv
// Shared definitions for the krnl_proj_split deadlock debug logic.
package krnl_proj_split_dbg_pkg;

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    REPORT  = 2'd1,
    LATCHED = 2'd2
  } dbg_state_e;

  localparam int unsigned DEFAULT_PERSIST_CYCLES = 1024;
  localparam int unsigned DEFAULT_TS_W           = 32;

endpackage

// File: rtl/krnl_proj_split_prio_enc.sv
// Lowest-set-bit priority encoder; returns 0 when no bit is set.
module krnl_proj_split_prio_enc
  import krnl_proj_split_dbg_pkg::*;
#(
  parameter int unsigned NUM_IN = 8,
  parameter int unsigned IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic [NUM_IN-1:0] in_vec,
  output logic [IDX_W-1:0]  idx
);

  // Scan from the top down so the lowest set bit is written last and wins.
  always_comb begin
    idx = '0;
    for (int unsigned i = NUM_IN; i > 0; i--) begin
      if (in_vec[i-1]) idx = IDX_W'(i - 1);
    end
  end

endmodule

// File: rtl/krnl_proj_split_hls_deadlock_reporter.sv
// Confirms a persistent all-blocked condition across the dataflow processes
// and emits one snapshot report, then holds a sticky deadlock flag.
module krnl_proj_split_hls_deadlock_reporter
  import krnl_proj_split_dbg_pkg::*;
#(
  parameter int unsigned NUM_PROC       = 8,
  parameter int unsigned PERSIST_CYCLES = DEFAULT_PERSIST_CYCLES,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TS_W           = DEFAULT_TS_W,
  localparam int unsigned IDX_W         = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic [NUM_PROC-1:0] proc_block,
  input  logic [NUM_PROC-1:0] proc_idle,
  output logic                report_valid,
  input  logic                report_ready,
  output logic [NUM_PROC-1:0] report_mask,
  output logic [IDX_W-1:0]    report_idx,
  output logic [TS_W-1:0]     report_ts,
  output logic                deadlock,
  output logic [CNT_W-1:0]    busy_cnt
);

  generate
    if (NUM_PROC < 1 || NUM_PROC > 32 || PERSIST_CYCLES < 2 ||
        (64'(PERSIST_CYCLES) >> CNT_W) != 64'd0) begin : g_bad_params
      $error("krnl_proj_split_hls_deadlock_reporter: illegal parameter set");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERSIST_CYCLES - 1);

  dbg_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TS_W-1:0]     ts_q, ts_d;
  logic                valid_q, valid_d;
  logic                dead_q, dead_d;
  logic [NUM_PROC-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TS_W-1:0]     rts_q, rts_d;
  logic [IDX_W-1:0]    low_idx;
  logic                cand;

  krnl_proj_split_prio_enc #(
    .NUM_IN (NUM_PROC),
    .IDX_W  (IDX_W)
  ) u_prio_enc (
    .in_vec (proc_block),
    .idx    (low_idx)
  );

  // Idle processes are excused, but at least one must actually be blocked.
  assign cand = enable & (|proc_block) & (&(proc_block | proc_idle));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    dead_d  = dead_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    rts_d   = rts_q;
    ts_d    = (ts_q == '1) ? ts_q : ts_q + TS_W'(1);

    case (state_q)
      MONITOR: begin
        if (cand) begin
          if (cnt_q == CNT_LAST) begin
            mask_d  = proc_block;
            idx_d   = low_idx;
            rts_d   = ts_q;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = REPORT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      REPORT: begin
        if (report_ready) begin
          valid_d = 1'b0;
          dead_d  = 1'b1;
          state_d = LATCHED;
        end
      end
      LATCHED: begin
        cnt_d = '0;
        if (clear) begin
          dead_d  = 1'b0;
          state_d = MONITOR;
        end
      end
      default: begin
        state_d = MONITOR;
        cnt_d   = '0;
        valid_d = 1'b0;
        dead_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= MONITOR;
      cnt_q   <= '0;
      ts_q    <= '0;
      valid_q <= 1'b0;
      dead_q  <= 1'b0;
      mask_q  <= '0;
      idx_q   <= '0;
      rts_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ts_q    <= ts_d;
      valid_q <= valid_d;
      dead_q  <= dead_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      rts_q   <= rts_d;
    end
  end

  assign report_valid = valid_q;
  assign deadlock     = dead_q;
  assign report_mask  = mask_q;
  assign report_idx   = idx_q;
  assign report_ts    = rts_q;
  assign busy_cnt     = cnt_q;

endmodule

// File: tb/tb_krnl_proj_split_hls_deadlock_reporter.sv
// Directed bench for the deadlock reporter with a cycle-level reference model.
module tb_krnl_proj_split_hls_deadlock_reporter;

  localparam int PERSIST = 4;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        clear;
  logic [3:0]  proc_block;
  logic [3:0]  proc_idle;
  logic        report_valid;
  logic        report_ready;
  logic [3:0]  report_mask;
  logic [1:0]  report_idx;
  logic [31:0] report_ts;
  logic        deadlock;
  logic [7:0]  busy_cnt;

  int checks = 0;
  int passes = 0;

  krnl_proj_split_hls_deadlock_reporter #(
    .NUM_PROC       (4),
    .PERSIST_CYCLES (PERSIST),
    .CNT_W          (8),
    .TS_W           (32)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .clear        (clear),
    .proc_block   (proc_block),
    .proc_idle    (proc_idle),
    .report_valid (report_valid),
    .report_ready (report_ready),
    .report_mask  (report_mask),
    .report_idx   (report_idx),
    .report_ts    (report_ts),
    .deadlock     (deadlock),
    .busy_cnt     (busy_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [1:0] lowest(input logic [3:0] v);
    int k = 0;
    while (k < 3 && !v[k]) k++;
    return 2'(k);
  endfunction

  // Reference model: run length of consecutive candidate cycles plus
  // pending-report and sticky-flag booleans.
  int          m_run   = 0;
  bit          m_valid = 0;
  bit          m_dead  = 0;
  logic [3:0]  m_mask  = '0;
  logic [1:0]  m_idx   = '0;
  logic [31:0] m_ts    = '0;
  logic [31:0] m_time  = '0;

  always @(posedge clock) begin
    bit c;
    if (reset) begin
      m_run = 0; m_valid = 0; m_dead = 0;
      m_mask = '0; m_idx = '0; m_ts = '0; m_time = '0;
    end else begin
      c = enable && (proc_block != 4'b0) && ((proc_block | proc_idle) == 4'hF);
      if (m_valid) begin
        if (report_ready) begin
          m_valid = 0;
          m_dead  = 1;
        end
      end else if (m_dead) begin
        if (clear) m_dead = 0;
      end else begin
        m_run = c ? m_run + 1 : 0;
        if (m_run == PERSIST) begin
          m_valid = 1;
          m_mask  = proc_block;
          m_idx   = lowest(proc_block);
          m_ts    = m_time;
          m_run   = 0;
        end
      end
      if (m_time != 32'hFFFF_FFFF) m_time = m_time + 1;
    end
  end

  always @(negedge clock) begin
    chk("m_valid", 64'(report_valid), 64'(m_valid));
    chk("m_dead",  64'(deadlock),     64'(m_dead));
    chk("m_busy",  64'(busy_cnt),     64'(m_run));
    chk("m_mask",  64'(report_mask),  64'(m_mask));
    chk("m_idx",   64'(report_idx),   64'(m_idx));
    chk("m_ts",    64'(report_ts),    64'(m_ts));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0;
    proc_block = '0; proc_idle = '0; report_ready = 1'b0;
    cyc(2);
    chk("rst_valid", 64'(report_valid), 64'd0);
    chk("rst_busy",  64'(busy_cnt),     64'd0);

    // Basic confirmation: four candidate cycles, ts of the capture edge is 3.
    reset = 1'b0; enable = 1'b1; proc_block = 4'b0011; proc_idle = 4'b1100;
    cyc(3);
    chk("s1_not_yet", 64'(report_valid), 64'd0);
    chk("s1_cnt3",    64'(busy_cnt),     64'd3);
    cyc(1);
    chk("s1_valid", 64'(report_valid), 64'd1);
    chk("s1_mask",  64'(report_mask),  64'h3);
    chk("s1_idx",   64'(report_idx),   64'd0);
    chk("s1_ts",    64'(report_ts),    64'd3);

    // Backpressure: inputs change and clear pulses, report must hold.
    proc_block = 4'b0000; proc_idle = 4'b1111; clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    cyc(9);
    chk("s3_hold_valid", 64'(report_valid), 64'd1);
    chk("s3_hold_mask",  64'(report_mask),  64'h3);
    chk("s3_hold_ts",    64'(report_ts),    64'd3);
    chk("s3_no_dead",    64'(deadlock),     64'd0);
    report_ready = 1'b1;
    cyc(1);
    report_ready = 1'b0;
    chk("s3_hs_valid", 64'(report_valid), 64'd0);
    chk("s3_hs_dead",  64'(deadlock),     64'd1);

    // Latched with blocks present; clear restarts counting.
    proc_block = 4'b0011; proc_idle = 4'b1100;
    cyc(2);
    chk("s4_latched", 64'(deadlock), 64'd1);
    chk("s4_cnt0",    64'(busy_cnt), 64'd0);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("s4_cleared", 64'(deadlock), 64'd0);
    cyc(3);
    chk("s4_not_yet", 64'(report_valid), 64'd0);
    cyc(1);
    chk("s4_valid", 64'(report_valid), 64'd1);
    chk("s4_mask",  64'(report_mask),  64'h3);
    report_ready = 1'b1;
    cyc(1);
    report_ready = 1'b0;
    proc_block = 4'b0000; proc_idle = 4'b1111; clear = 1'b1;
    cyc(1);
    clear = 1'b0;

    // No-candidate patterns: all idle, then disabled with blocks.
    cyc(6);
    chk("s5_idle_busy",  64'(busy_cnt),     64'd0);
    chk("s5_idle_valid", 64'(report_valid), 64'd0);
    enable = 1'b0; proc_block = 4'b0011; proc_idle = 4'b1100;
    cyc(6);
    chk("s5_dis_busy",  64'(busy_cnt),     64'd0);
    chk("s5_dis_valid", 64'(report_valid), 64'd0);

    // One-cycle drop of proc_block[1] after three candidate cycles.
    enable = 1'b1;
    cyc(3);
    chk("s2_cnt3", 64'(busy_cnt), 64'd3);
    proc_block = 4'b0001;
    cyc(1);
    chk("s2_restart", 64'(busy_cnt), 64'd0);
    proc_block = 4'b0011;
    cyc(3);
    chk("s2_cnt3b",   64'(busy_cnt),     64'd3);
    chk("s2_not_yet", 64'(report_valid), 64'd0);
    cyc(1);
    chk("s2_valid", 64'(report_valid), 64'd1);
    chk("s2_idx",   64'(report_idx),   64'd0);

    // Reset while a report is pending, then a fresh report with idx 2.
    reset = 1'b1;
    cyc(1);
    chk("s6_valid", 64'(report_valid), 64'd0);
    chk("s6_dead",  64'(deadlock),     64'd0);
    chk("s6_busy",  64'(busy_cnt),     64'd0);
    reset = 1'b0; proc_block = 4'b1100; proc_idle = 4'b0011;
    cyc(4);
    chk("s6_rearm_valid", 64'(report_valid), 64'd1);
    chk("s6_rearm_mask",  64'(report_mask),  64'hC);
    chk("s6_rearm_idx",   64'(report_idx),   64'd2);
    chk("s6_rearm_ts",    64'(report_ts),    64'd3);

    cyc(1);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
